// File: rtl/dcfifo_usedw_gen.sv
// dcfifo_usedw_gen: one side of a dual-clock FIFO. It holds the local pointer, publishes
// it as Gray code, synchronizes the remote Gray pointer and derives the occupancy.
module dcfifo_usedw_gen #(
  parameter int    lpm_widthad        = 4,
  parameter int    lpm_numwords       = 16,
  parameter string lpm_mode           = "WRITE",
  parameter int    lpm_sync_stages    = 2,
  parameter string overflow_checking  = "ON",
  parameter string underflow_checking = "ON"
) (
  input  logic                   clock,
  input  logic                   aclr,
  input  logic                   req,
  input  logic [lpm_widthad:0]   remote_gray,
  output logic [lpm_widthad:0]   local_gray,
  output logic [lpm_widthad-1:0] addr,
  output logic                   accept,
  output logic [lpm_widthad:0]   count,
  output logic [lpm_widthad-1:0] usedw
);
  localparam int W = lpm_widthad;
  localparam int S = (lpm_sync_stages < 2) ? 2 : lpm_sync_stages;
  localparam bit IS_WRITE = (lpm_mode == "WRITE");
  localparam bit CHECK_ON = IS_WRITE ? (overflow_checking == "ON") : (underflow_checking == "ON");
  localparam logic [W:0] FULL = (W+1)'(lpm_numwords);

  if (lpm_numwords != (1 << lpm_widthad)) begin : g_bad_depth
    $error("dcfifo_usedw_gen: lpm_numwords must equal 2**lpm_widthad");
  end
  if (lpm_mode != "WRITE" && lpm_mode != "READ") begin : g_bad_mode
    $error("dcfifo_usedw_gen: lpm_mode must be WRITE or READ");
  end

  logic [W:0] lptr;
  logic [W:0] lptr_next;
  logic [W:0] rbin;
  logic [W:0] sync_q [S];
  logic       blocked;
  logic       overrun;
  logic       overrun_q;

  always_comb begin
    rbin[W] = sync_q[S-1][W];
    for (int i = W - 1; i >= 0; i--) begin
      rbin[i] = rbin[i+1] ^ sync_q[S-1][i];
    end
  end

  // Subtraction wraps modulo 2^(W+1); the extra pointer bit disambiguates full from empty.
  assign count   = IS_WRITE ? (lptr - rbin) : (rbin - lptr);
  assign usedw   = count[W-1:0];
  assign addr    = lptr[W-1:0];
  assign blocked = CHECK_ON && (IS_WRITE ? (count == FULL) : (count == '0));
  assign accept  = req & ~blocked & ~aclr;
  assign lptr_next = accept ? lptr + 1'b1 : lptr;
  assign overrun = (count > FULL);

  // Gray is registered from lptr_next so local_gray always matches gray(lptr) glitch-free.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      lptr       <= '0;
      local_gray <= '0;
      overrun_q  <= 1'b0;
      for (int i = 0; i < S; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      lptr       <= lptr_next;
      local_gray <= lptr_next ^ (lptr_next >> 1);
      overrun_q  <= overrun;
      sync_q[0]  <= remote_gray;
      for (int i = 1; i < S; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      assert (!(overrun && !overrun_q))
        else $error("Error! dcfifo_usedw_gen pointer overrun.");
    end
  end

endmodule

// File: tb/tb_dcfifo_usedw_gen.sv
// tb_dcfifo_usedw_gen: directed bench with a WRITE-side and a READ-side instance sharing
// clock and reset; expected values are queued as stimulus is driven and popped on sampling.
module tb_dcfifo_usedw_gen;
  localparam int W = 4;

  typedef struct {
    string       tag;
    logic [31:0] value;
  } exp_t;

  logic         clock = 1'b0;
  logic         aclr;
  logic         wr_req, rd_req;
  logic [W:0]   wr_remote, rd_remote;
  logic [W:0]   wr_local_gray, rd_local_gray;
  logic [W-1:0] wr_addr, rd_addr;
  logic         wr_accept, rd_accept;
  logic [W:0]   wr_count, rd_count;
  logic [W-1:0] wr_usedw, rd_usedw;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  dcfifo_usedw_gen #(.lpm_widthad(W), .lpm_numwords(16), .lpm_mode("WRITE"),
                     .lpm_sync_stages(2), .overflow_checking("ON"), .underflow_checking("ON"))
  u_wr (.clock(clock), .aclr(aclr), .req(wr_req), .remote_gray(wr_remote),
        .local_gray(wr_local_gray), .addr(wr_addr), .accept(wr_accept),
        .count(wr_count), .usedw(wr_usedw));

  dcfifo_usedw_gen #(.lpm_widthad(W), .lpm_numwords(16), .lpm_mode("READ"),
                     .lpm_sync_stages(2), .overflow_checking("ON"), .underflow_checking("ON"))
  u_rd (.clock(clock), .aclr(aclr), .req(rd_req), .remote_gray(rd_remote),
        .local_gray(rd_local_gray), .addr(rd_addr), .accept(rd_accept),
        .count(rd_count), .usedw(rd_usedw));

  function automatic logic [W:0] gray(input int b);
    logic [W:0] v;
    v = b[W:0];
    return v ^ (v >> 1);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_stimulus(input logic a, input logic wq, input logic rq,
                                input logic [W:0] wrem, input logic [W:0] rrem);
    aclr      = a;
    wr_req    = wq;
    rd_req    = rq;
    wr_remote = wrem;
    rd_remote = rrem;
  endtask

  task automatic push_exp(input string tag, input logic [31:0] value);
    exp_t e;
    e.tag   = tag;
    e.value = value;
    sb_q.push_back(e);
  endtask

  task automatic check_output(input logic [31:0] observed);
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=%0h expected=<none>", observed);
    end else begin
      e = sb_q.pop_front();
      assert (observed === e.value)
        else begin
          failures++;
          $error("FAIL %s observed=%0h expected=%0h", e.tag, observed, e.value);
        end
    end
  endtask

  initial begin
    int         taken;
    logic [W:0] prev_gray;
    int         rd_exp [6];

    // Reset held from time 0: outputs must already be clear before the first edge.
    apply_stimulus(1'b1, 1'b0, 1'b0, '0, '0);
    #1;
    push_exp("rst_gray", 0);  check_output(32'(wr_local_gray));
    push_exp("rst_addr", 0);  check_output(32'(wr_addr));
    push_exp("rst_count", 0); check_output(32'(wr_count));
    push_exp("rst_usedw", 0); check_output(32'(wr_usedw));
    wr_req = 1'b1;
    #1;
    push_exp("rst_accept", 0); check_output(32'(wr_accept));
    tick();
    apply_stimulus(1'b0, 1'b0, 1'b0, '0, '0);

    // Five accepted writes against an idle reader.
    wr_req = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    wr_req = 1'b0;
    push_exp("w5_count", 5);         check_output(32'(wr_count));
    push_exp("w5_addr", 5);          check_output(32'(wr_addr));
    push_exp("w5_gray", 32'b00111);  check_output(32'(wr_local_gray));

    // Remote pointer 3 takes two edges to reach count.
    wr_remote = gray(3);
    tick();
    push_exp("sync_edge_n", 5);   check_output(32'(wr_count));
    tick();
    push_exp("sync_edge_n1", 2);  check_output(32'(wr_count));

    // Advance to lptr=9, then assert reset between edges.
    wr_req = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    wr_req = 1'b0;
    push_exp("pre_rst_addr", 9);  check_output(32'(wr_addr));
    #2;
    aclr   = 1'b1;
    wr_req = 1'b1;
    #1;
    push_exp("arst_gray", 0);   check_output(32'(wr_local_gray));
    push_exp("arst_addr", 0);   check_output(32'(wr_addr));
    push_exp("arst_count", 0);  check_output(32'(wr_count));
    push_exp("arst_usedw", 0);  check_output(32'(wr_usedw));
    push_exp("arst_accept", 0); check_output(32'(wr_accept));
    wr_remote = '0;
    #2;
    aclr = 1'b0;
    tick();
    wr_req = 1'b0;
    push_exp("post_rst_addr", 1); check_output(32'(wr_addr));

    // Full boundary: 20 requests, remote held at zero.
    aclr = 1'b1;
    #2;
    aclr = 1'b0;
    tick();
    taken  = 0;
    wr_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      push_exp($sformatf("full_accept_%0d", i), (i < 16) ? 1 : 0);
      check_output(32'(wr_accept));
      if (wr_accept) taken++;
      tick();
    end
    wr_req = 1'b0;
    push_exp("full_taken", 16);  check_output(32'(taken));
    push_exp("full_count", 16);  check_output(32'(wr_count));
    push_exp("full_usedw", 0);   check_output(32'(wr_usedw));

    // Wrap: 40 writes while the remote pointer trails two edges behind.
    aclr = 1'b1;
    #2;
    aclr = 1'b0;
    tick();
    prev_gray = wr_local_gray;
    wr_req    = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      push_exp($sformatf("wrap_gray_%0d", k), 32'(gray(k & 31)));
      check_output(32'(wr_local_gray));
      push_exp($sformatf("wrap_onebit_%0d", k), 1);
      check_output(32'($countones(prev_gray ^ wr_local_gray)));
      push_exp($sformatf("wrap_count_%0d", k), (k < 2) ? k : 2);
      check_output(32'(wr_count));
      prev_gray = wr_local_gray;
      wr_remote = gray(k & 31);
    end
    wr_req = 1'b0;
    tick();
    tick();
    push_exp("wrap_final_count", 0); check_output(32'(wr_count));
    push_exp("wrap_final_addr", 8);  check_output(32'(wr_addr));

    // READ side: empty blocks, then exactly two reads once remote=2 is synchronized.
    rd_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_exp($sformatf("rd_empty_accept_%0d", i), 0); check_output(32'(rd_accept));
      tick();
    end
    push_exp("rd_empty_addr", 0); check_output(32'(rd_addr));
    rd_remote = gray(2);
    rd_exp    = '{0, 0, 1, 1, 0, 0};
    taken     = 0;
    for (int j = 0; j < 6; j++) begin
      push_exp($sformatf("rd_accept_%0d", j), 32'(rd_exp[j]));
      check_output(32'(rd_accept));
      if (rd_accept) taken++;
      tick();
    end
    rd_req = 1'b0;
    push_exp("rd_taken", 2);  check_output(32'(taken));
    push_exp("rd_count", 0);  check_output(32'(rd_count));
    push_exp("rd_addr", 2);   check_output(32'(rd_addr));

    checks++;
    assert (sb_q.size() == 0)
      else begin
        failures++;
        $error("FAIL scoreboard_drain observed=%0d expected=0", sb_q.size());
      end

    $display("[TB] directed sequence complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
